// File: rtl/dma_prog_master.sv
// dma_prog_master
//   CPU-side initiator producing 8237-style program-mode bus cycles.
//   Each request becomes one or two byte cycles (SETUP -> STROBE -> HOLD),
//   followed by a one-clock completion pulse (DONE).
//
// Ports
//   CLK, RESET_N            clock, asynchronous active-low reset
//   HLDA                    DMA owns the bus; requests are blocked while high
//   req_valid/req_ready     request handshake
//   req_write/req_reg/
//   req_wide/req_data       request fields, sampled only on the accept clock
//   rsp_valid/rsp_data      one-clock completion pulse with read data
//   CS_N/IOR_N/IOW_N/A      program-mode bus control and address
//   DB_OUT/DB_OE/DB_IN      data bus (split in/out with drive enable)
//   ff_state                mirror of the DMA byte-pointer flip-flop
//   prot_err                sticky: HLDA rose while a cycle was active
//
// Optional build macro
//   AUTO_FF_CLEAR_EN        wide requests with ff_state=1 are preceded by a
//                           clear-flip-flop write (register 4'hC, data 0)
module dma_prog_master #(
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        HLDA,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [3:0]  req_reg,
    input  logic        req_wide,
    input  logic [15:0] req_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        CS_N,
    output logic        IOR_N,
    output logic        IOW_N,
    output logic [3:0]  A,
    output logic [7:0]  DB_OUT,
    output logic        DB_OE,
    input  logic [7:0]  DB_IN,
    output logic        ff_state,
    output logic        prot_err
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE} state_t;

    localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [3:0]  reg_q, reg_d;
    logic        wide_q, wide_d;
    logic [15:0] data_q, data_d;
    logic        byte_q, byte_d;     // 0 = low byte lane, 1 = high byte lane
    logic        pre_q, pre_d;       // clear-FF prefix cycle in progress
    logic [15:0] rd_q, rd_d;
    logic        ff_q, ff_d;
    logic        prot_q, prot_d;
    logic        hlda_q;
    logic        rdy_en_q;           // keeps req_ready low while in reset

    logic [3:0]  cur_reg;
    logic        cur_wr;
    logic [7:0]  cur_byte;
    logic        active;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            reg_q    <= '0;
            wide_q   <= 1'b0;
            data_q   <= '0;
            byte_q   <= 1'b0;
            pre_q    <= 1'b0;
            rd_q     <= '0;
            ff_q     <= 1'b0;
            prot_q   <= 1'b0;
            hlda_q   <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            reg_q    <= reg_d;
            wide_q   <= wide_d;
            data_q   <= data_d;
            byte_q   <= byte_d;
            pre_q    <= pre_d;
            rd_q     <= rd_d;
            ff_q     <= ff_d;
            prot_q   <= prot_d;
            hlda_q   <= HLDA;
            rdy_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        reg_d   = reg_q;
        wide_d  = wide_q;
        data_d  = data_q;
        byte_d  = byte_q;
        pre_d   = pre_q;
        rd_d    = rd_q;
        ff_d    = ff_q;
        prot_d  = prot_q;

        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        CS_N      = 1'b1;
        IOR_N     = 1'b1;
        IOW_N     = 1'b1;
        A         = '0;
        DB_OUT    = '0;
        DB_OE     = 1'b0;

        // The prefix cycle overrides the latched request with a clear-FF write.
        cur_reg  = pre_q ? 4'hC : reg_q;
        cur_wr   = pre_q | write_q;
        cur_byte = pre_q ? 8'h00 : (byte_q ? data_q[15:8] : data_q[7:0]);
        active   = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_HOLD);

        if (active) begin
            CS_N = 1'b0;
            A    = cur_reg;
            if (cur_wr) begin
                DB_OE  = 1'b1;
                DB_OUT = cur_byte;
            end
            if (HLDA && !hlda_q) prot_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                req_ready = rdy_en_q && !HLDA;
                if (req_valid && rdy_en_q && !HLDA) begin
                    write_d = req_write;
                    reg_d   = req_reg;
                    wide_d  = req_wide && !req_reg[3];
                    data_d  = req_data;
                    byte_d  = 1'b0;
                    rd_d    = '0;
                    cnt_d   = '0;
`ifdef AUTO_FF_CLEAR_EN
                    pre_d   = req_wide && !req_reg[3] && ff_q;
`else
                    pre_d   = 1'b0;
`endif
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_STROBE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_STROBE: begin
                IOW_N = !cur_wr;
                IOR_N = cur_wr;
                if (cnt_q == STROBE_LAST) begin
                    if (!cur_wr) begin
                        if (byte_q) rd_d[15:8] = DB_IN;
                        else        rd_d[7:0]  = DB_IN;
                    end
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    if (cur_wr && ((cur_reg == 4'hC) || (cur_reg == 4'hD))) ff_d = 1'b0;
                    else if (!cur_reg[3])                                    ff_d = ~ff_q;
                    if (pre_q) begin
                        pre_d   = 1'b0;
                        state_d = S_SETUP;
                    end else if (wide_q && !byte_q) begin
                        byte_d  = 1'b1;
                        state_d = S_SETUP;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                rsp_data  = write_q ? 16'h0000 : rd_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ff_state = ff_q;
    assign prot_err = prot_q;

endmodule
